// File: rtl/sync_step_checker.sv
// sync_step_checker
//   Samples an asynchronous WIDTH-bit bus through a DEPTH-stage flop chain.
//   Each change of the synchronized value is classified as a legal step or an
//   error. Legal means binary +1 (mod 2^WIDTH) when GRAY=0, and exactly one
//   flipped bit when GRAY=1.
//   The block keeps saturating step/error counters and captures the first
//   violating (prev, curr) pair.
//   Optional stuck detector: define SYNC_STEP_CHECKER_STUCK_EN to enable it.
//   When the macro is undefined, stuck is tied to 0.
module sync_step_checker #(
    parameter int WIDTH   = 4,
    parameter int DEPTH   = 2,
    parameter int CNT_W   = 8,
    parameter int GRAY    = 0,
    parameter int STUCK_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_in,
    input  logic             enable,
    input  logic             clear,
    output logic [WIDTH-1:0] sync_out,
    output logic             step_pulse,
    output logic             err_pulse,
    output logic [CNT_W-1:0] step_count,
    output logic [CNT_W-1:0] err_count,
    output logic             cap_valid,
    output logic [WIDTH-1:0] cap_prev,
    output logic [WIDTH-1:0] cap_curr,
    output logic             stuck
);

    // The prime counter must be able to hold the value DEPTH.
    localparam int PRIME_W = $clog2(DEPTH + 2);
    localparam logic [PRIME_W-1:0] PRIME_LAST = PRIME_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t             state_reg;
    logic [PRIME_W-1:0] prime_cnt_reg;
    logic [WIDTH-1:0]   sync_val;
    logic [WIDTH-1:0]   prev_reg;
    logic [WIDTH-1:0]   prev_inc;
    logic [WIDTH-1:0]   diff;
    logic               changed;
    logic               legal;
    logic               compare_en;
    logic               step_event;
    logic               err_event;
    logic               step_pulse_reg;
    logic               err_pulse_reg;
    logic               cap_valid_reg;
    logic [WIDTH-1:0]   cap_prev_reg;
    logic [WIDTH-1:0]   cap_curr_reg;
    logic [1:0]         cnt_event;

    // Synchronizer chain. Each stage has its own register, and the chain shifts every cycle.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [WIDTH-1:0] stage_reg;
            logic [WIDTH-1:0] stage_next;
            if (gi == 0) begin : g_first
                assign stage_next = async_in;
            end else begin : g_rest
                assign stage_next = g_stage[gi-1].stage_reg;
            end
            // Shift one stage per clock; reset clears the whole chain.
            always_ff @(posedge clk) begin
                if (rst) begin
                    stage_reg <= '0;
                end else begin
                    stage_reg <= stage_next;
                end
            end
        end
    endgenerate

    assign sync_val = g_stage[DEPTH-1].stage_reg;

    // Previous synchronized value, updated every cycle regardless of the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_reg <= '0;
        end else begin
            prev_reg <= sync_val;
        end
    end

    // Step classification.
    assign diff     = sync_val ^ prev_reg;
    assign prev_inc = prev_reg + 1'b1;
    assign changed  = (diff != '0);

    generate
        if (GRAY != 0) begin : g_gray
            // A Gray step flips exactly one bit, so diff must be one-hot.
            assign legal = changed && ((diff & (diff - 1'b1)) == '0);
        end else begin : g_bin
            // A binary step is +1; the all-ones to zero wrap is also legal.
            assign legal = (sync_val == prev_inc);
        end
    endgenerate

    assign compare_en = (state_reg == ST_RUN) && enable;
    assign step_event = compare_en && changed && legal;
    assign err_event  = compare_en && changed && !legal;

    // Control FSM. Dropping enable always returns to IDLE. PRIME lasts
    // DEPTH+1 cycles, so prev and sync_out hold only post-enable samples
    // before the first compare.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            state_reg     <= ST_IDLE;
            prime_cnt_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    state_reg     <= ST_PRIME;
                    prime_cnt_reg <= '0;
                end
                ST_PRIME: begin
                    if (prime_cnt_reg == PRIME_LAST) begin
                        state_reg <= ST_RUN;
                    end else begin
                        prime_cnt_reg <= prime_cnt_reg + 1'b1;
                    end
                end
                ST_RUN: begin
                    state_reg <= ST_RUN;
                end
                default: begin
                    state_reg     <= ST_IDLE;
                    prime_cnt_reg <= '0;
                end
            endcase
        end
    end

    // Registered event pulses. clear does not suppress them.
    always_ff @(posedge clk) begin
        if (rst) begin
            step_pulse_reg <= 1'b0;
            err_pulse_reg  <= 1'b0;
        end else begin
            step_pulse_reg <= step_event;
            err_pulse_reg  <= err_event;
        end
    end

    // Saturating event counters: index 0 counts steps, index 1 counts errors.
    assign cnt_event = {err_event, step_event};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] count_reg;
            // clear takes priority over a coincident event.
            always_ff @(posedge clk) begin
                if (rst || clear) begin
                    count_reg <= '0;
                end else if (cnt_event[gi] && (count_reg != '1)) begin
                    count_reg <= count_reg + 1'b1;
                end
            end
        end
    endgenerate

    // Capture the first violating pair. It is held until clear or reset.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cap_valid_reg <= 1'b0;
            cap_prev_reg  <= '0;
            cap_curr_reg  <= '0;
        end else if (err_event && !cap_valid_reg) begin
            cap_valid_reg <= 1'b1;
            cap_prev_reg  <= prev_reg;
            cap_curr_reg  <= sync_val;
        end
    end

`ifdef SYNC_STEP_CHECKER_STUCK_EN
    logic [STUCK_W-1:0] stuck_timer_reg;
    logic [STUCK_W-1:0] stuck_timer_next;
    logic               stuck_reg;

    // Count consecutive unchanged compares. The count restarts on any change
    // and whenever the FSM is not comparing.
    always_comb begin
        stuck_timer_next = '0;
        if (compare_en && !changed) begin
            if (stuck_timer_reg == '1) begin
                stuck_timer_next = stuck_timer_reg;
            end else begin
                stuck_timer_next = stuck_timer_reg + 1'b1;
            end
        end
    end

    // The timer advances every cycle. stuck latches when the timer hits all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            stuck_timer_reg <= '0;
            stuck_reg       <= 1'b0;
        end else begin
            stuck_timer_reg <= stuck_timer_next;
            if (clear) begin
                stuck_reg <= 1'b0;
            end else if (stuck_timer_next == '1) begin
                stuck_reg <= 1'b1;
            end
        end
    end

    assign stuck = stuck_reg;
`else
    // Stuck detection is compiled out. STUCK_W >= 1, so this constant is always 0.
    localparam logic STUCK_TIE = (STUCK_W < 1);
    assign stuck = STUCK_TIE;
`endif

    assign sync_out   = sync_val;
    assign step_pulse = step_pulse_reg;
    assign err_pulse  = err_pulse_reg;
    assign step_count = g_cnt[0].count_reg;
    assign err_count  = g_cnt[1].count_reg;
    assign cap_valid  = cap_valid_reg;
    assign cap_prev   = cap_prev_reg;
    assign cap_curr   = cap_curr_reg;

endmodule

// File: tb/tb_sync_step_checker.sv
// Testbench for sync_step_checker.
//   Two instances share the same stimulus:
//     u_bin  : GRAY=0, CNT_W=8
//     u_gray : GRAY=1, CNT_W=4
//   A history-based reference model predicts every output. The model's
//   predictions are compared with both instances on every falling edge.
//   Directed literal checks pin the test-plan scenarios, and a random
//   phase runs after them.
module tb_sync_step_checker;

    localparam int DEPTH = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] async_in;
    logic       enable;
    logic       clear;

    logic [3:0] sync_out_b, cap_prev_b, cap_curr_b;
    logic [7:0] step_count_b, err_count_b;
    logic       step_pulse_b, err_pulse_b, cap_valid_b, stuck_b;

    logic [3:0] sync_out_g, cap_prev_g, cap_curr_g;
    logic [3:0] step_count_g, err_count_g;
    logic       step_pulse_g, err_pulse_g, cap_valid_g, stuck_g;

    int checks   = 0;
    int failures = 0;
    int sp_seen_b = 0;

    always #5 clk = ~clk;

    sync_step_checker #(.WIDTH(4), .DEPTH(DEPTH), .CNT_W(8), .GRAY(0), .STUCK_W(8)) u_bin (
        .clk(clk), .rst(rst), .async_in(async_in), .enable(enable), .clear(clear),
        .sync_out(sync_out_b), .step_pulse(step_pulse_b), .err_pulse(err_pulse_b),
        .step_count(step_count_b), .err_count(err_count_b), .cap_valid(cap_valid_b),
        .cap_prev(cap_prev_b), .cap_curr(cap_curr_b), .stuck(stuck_b)
    );

    sync_step_checker #(.WIDTH(4), .DEPTH(DEPTH), .CNT_W(4), .GRAY(1), .STUCK_W(8)) u_gray (
        .clk(clk), .rst(rst), .async_in(async_in), .enable(enable), .clear(clear),
        .sync_out(sync_out_g), .step_pulse(step_pulse_g), .err_pulse(err_pulse_g),
        .step_count(step_count_g), .err_count(err_count_g), .cap_valid(cap_valid_g),
        .cap_prev(cap_prev_g), .cap_curr(cap_curr_g), .stuck(stuck_g)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // hist[j] is the bus value sampled j edges ago (0 while in reset).
    // A compare happens once enable has been high for DEPTH+3 consecutive
    // edges: one IDLE edge, DEPTH+1 PRIME edges, then RUN.
    logic [3:0] hist [DEPTH+2] = '{default: 4'h0};
    int  en_run = 0;
    bit  model_live = 1'b0;
    int  cnt_max [2] = '{255, 15};
    int  m_step [2], m_err [2], m_timer [2];
    bit  m_sp [2], m_ep [2], m_cv [2], m_stuck [2];
    logic [3:0] m_cp [2], m_cc [2];
    logic [3:0] m_sync = 4'h0;
    localparam int SMAX = 255;

    always @(posedge clk) begin : model
        int  cur, prv;
        bit  cmp, chg, legal;
        if (rst) begin
            for (int i = 0; i < DEPTH + 2; i++) hist[i] = 4'h0;
            en_run = 0;
            for (int g = 0; g < 2; g++) begin
                m_step[g] = 0; m_err[g] = 0; m_timer[g] = 0;
                m_sp[g] = 0; m_ep[g] = 0; m_cv[g] = 0; m_stuck[g] = 0;
                m_cp[g] = 4'h0; m_cc[g] = 4'h0;
            end
            model_live = 1'b1;
        end else begin
            for (int i = DEPTH + 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = async_in;
            en_run = enable ? ((en_run < 1000) ? en_run + 1 : en_run) : 0;
            cmp = (en_run >= DEPTH + 3);
            cur = int'(hist[DEPTH]);
            prv = int'(hist[DEPTH+1]);
            chg = cmp && (cur != prv);
            for (int g = 0; g < 2; g++) begin
                if (g == 0) legal = (cur == ((prv + 1) % 16));
                else        legal = ($countones(cur ^ prv) == 1);
                m_sp[g] = chg && legal;
                m_ep[g] = chg && !legal;
                m_timer[g] = (cmp && !chg) ? ((m_timer[g] < SMAX) ? m_timer[g] + 1 : SMAX) : 0;
                if (clear) begin
                    m_step[g] = 0; m_err[g] = 0; m_cv[g] = 0;
                    m_cp[g] = 4'h0; m_cc[g] = 4'h0; m_stuck[g] = 0;
                end else begin
                    if (m_sp[g] && m_step[g] < cnt_max[g]) m_step[g]++;
                    if (m_ep[g] && m_err[g] < cnt_max[g]) m_err[g]++;
                    if (m_ep[g] && !m_cv[g]) begin
                        m_cv[g] = 1; m_cp[g] = prv[3:0]; m_cc[g] = cur[3:0];
                    end
`ifdef SYNC_STEP_CHECKER_STUCK_EN
                    if (m_timer[g] == SMAX) m_stuck[g] = 1;
`endif
                end
            end
        end
        m_sync = hist[DEPTH-1];
    end

    // ---------------- every-cycle comparison ----------------
    always @(negedge clk) begin
        if (model_live) begin
            chk("bin.sync_out",    32'(sync_out_b),   32'(m_sync));
            chk("bin.step_pulse",  32'(step_pulse_b), 32'(m_sp[0]));
            chk("bin.err_pulse",   32'(err_pulse_b),  32'(m_ep[0]));
            chk("bin.step_count",  32'(step_count_b), 32'(m_step[0]));
            chk("bin.err_count",   32'(err_count_b),  32'(m_err[0]));
            chk("bin.cap_valid",   32'(cap_valid_b),  32'(m_cv[0]));
            chk("bin.cap_prev",    32'(cap_prev_b),   32'(m_cp[0]));
            chk("bin.cap_curr",    32'(cap_curr_b),   32'(m_cc[0]));
            chk("bin.stuck",       32'(stuck_b),      32'(m_stuck[0]));
            chk("gray.sync_out",   32'(sync_out_g),   32'(m_sync));
            chk("gray.step_pulse", 32'(step_pulse_g), 32'(m_sp[1]));
            chk("gray.err_pulse",  32'(err_pulse_g),  32'(m_ep[1]));
            chk("gray.step_count", 32'(step_count_g), 32'(m_step[1]));
            chk("gray.err_count",  32'(err_count_g),  32'(m_err[1]));
            chk("gray.cap_valid",  32'(cap_valid_g),  32'(m_cv[1]));
            chk("gray.cap_prev",   32'(cap_prev_g),   32'(m_cp[1]));
            chk("gray.cap_curr",   32'(cap_curr_g),   32'(m_cc[1]));
            chk("gray.stuck",      32'(stuck_g),      32'(m_stuck[1]));
            if (step_pulse_b === 1'b1) sp_seen_b++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
    endtask

    initial begin
        rst = 1'b1; async_in = 4'hA; enable = 1'b0; clear = 1'b0;

        // Test 1: reset and synchronizer latency.
        cyc(2);
        rst = 1'b0;
        @(negedge clk);
        chk("t1.sync_out_reset",   32'(sync_out_b),   32'h0);
        chk("t1.step_count_reset", 32'(step_count_b), 32'h0);
        chk("t1.cap_valid_reset",  32'(cap_valid_g),  32'h0);
        cyc(1);
        @(negedge clk);
        chk("t1.sync_out_lat1", 32'(sync_out_b), 32'h0);
        cyc(1);
        @(negedge clk);
        chk("t1.sync_out_lat2", 32'(sync_out_b), 32'hA);
        cyc(4);
        chk("t1.err_count_idle", 32'(err_count_b), 32'h0);
        $display("[tb] test1 reset/latency done");

        // Test 2: binary count 0..F then wrap to 0.
        enable = 1'b1; async_in = 4'h0;
        cyc(8);
        do_clear();
        sp_seen_b = 0;
        for (int v = 1; v <= 16; v++) begin
            async_in = 4'(v % 16);
            cyc(3);
        end
        cyc(4);
        @(negedge clk);
        chk("t2.step_count", 32'(step_count_b), 32'd16);
        chk("t2.err_count",  32'(err_count_b),  32'd0);
        chk("t2.cap_valid",  32'(cap_valid_b),  32'd0);
        chk("t2.pulses",     32'(sp_seen_b),    32'd16);
        $display("[tb] test2 binary sweep done");

        // Test 3: binary sequence 3,4,7,9.
        async_in = 4'h3;
        cyc(6);
        do_clear();
        async_in = 4'h4; cyc(3);
        async_in = 4'h7; cyc(3);
        async_in = 4'h9; cyc(3);
        cyc(4);
        @(negedge clk);
        chk("t3.step_count", 32'(step_count_b), 32'd1);
        chk("t3.err_count",  32'(err_count_b),  32'd2);
        chk("t3.cap_valid",  32'(cap_valid_b),  32'd1);
        chk("t3.cap_prev",   32'(cap_prev_b),   32'h4);
        chk("t3.cap_curr",   32'(cap_curr_b),   32'h7);
        $display("[tb] test3 binary errors done");

        // Test 4: Gray sequence 0,1,3,0.
        async_in = 4'h0;
        cyc(6);
        do_clear();
        async_in = 4'h1; cyc(3);
        async_in = 4'h3; cyc(3);
        async_in = 4'h0; cyc(3);
        cyc(4);
        @(negedge clk);
        chk("t4.step_count", 32'(step_count_g), 32'd2);
        chk("t4.err_count",  32'(err_count_g),  32'd1);
        chk("t4.cap_prev",   32'(cap_prev_g),   32'h3);
        chk("t4.cap_curr",   32'(cap_curr_g),   32'h0);
        $display("[tb] test4 gray sequence done");

        // Test 5: saturation, then a clear that coincides with an error.
        do_clear();
        for (int i = 0; i < 20; i++) begin
            async_in = (i % 2 == 0) ? 4'h5 : 4'h0;
            cyc(3);
        end
        cyc(4);
        @(negedge clk);
        chk("t5.err_saturated", 32'(err_count_g), 32'd15);
        async_in = 4'h5;
        cyc(2);
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        @(negedge clk);
        chk("t5.err_pulse_on_clear", 32'(err_pulse_g), 32'd1);
        chk("t5.err_count_cleared",  32'(err_count_g), 32'd0);
        chk("t5.cap_valid_cleared",  32'(cap_valid_g), 32'd0);
        $display("[tb] test5 saturation/clear done");

        // Test 6: drop enable, change the bus illegally, then re-enable.
        cyc(3);
        enable = 1'b0;
        cyc(1);
        async_in = 4'h9;
        cyc(8);
        @(negedge clk);
        chk("t6.err_hold_b", 32'(err_count_b), 32'd0);
        chk("t6.err_hold_g", 32'(err_count_g), 32'd0);
        // This change is sampled while PRIME is still running, so it must never be compared.
        enable = 1'b1; async_in = 4'hA;
        cyc(8);
        @(negedge clk);
        chk("t6.prime_step_b", 32'(step_count_b), 32'd0);
        chk("t6.prime_err_b",  32'(err_count_b),  32'd0);
        async_in = 4'hB;
        cyc(4);
        @(negedge clk);
        chk("t6.first_step_b", 32'(step_count_b), 32'd1);
        cyc(300);
        @(negedge clk);
`ifdef SYNC_STEP_CHECKER_STUCK_EN
        chk("t6.stuck_set", 32'(stuck_b), 32'd1);
`else
        chk("t6.stuck_off", 32'(stuck_b), 32'd0);
`endif
        $display("[tb] test6 enable/prime/stuck done");

        // Random phase.
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 20)      async_in = async_in + 4'h1;
            else if (r < 35) async_in = async_in ^ (4'h1 << $urandom_range(0, 3));
            else if (r < 50) async_in = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 99) < 2) enable = ~enable;
            clear = ($urandom_range(0, 99) < 2);
            rst   = ($urandom_range(0, 199) == 0);
            cyc(1);
        end
        rst = 1'b0; clear = 1'b0;
        cyc(4);
        $display("[tb] random phase done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
